// File: rtl/zxuno_regbus_initiator_pkg.sv
// Shared definitions for the ZXUNO internal register bus initiator.
// Holds the Z80 I/O port addresses of the register-select and register-data
// ports, the register numbers of the standard configuration slaves, and the
// state encoding of the initiator FSM.
package zxuno_regbus_initiator_pkg;

   localparam logic [15:0] ZXUNO_ADDR_PORT = 16'hFC3B;
   localparam logic [15:0] ZXUNO_DATA_PORT = 16'hFD3B;

   // Register numbers of the configuration slaves on the bus
   localparam logic [7:0] REG_MASTERCONF   = 8'h00;
   localparam logic [7:0] REG_MASTERMAPPER = 8'h01;
   localparam logic [7:0] REG_FLASHSPI     = 8'h02;
   localparam logic [7:0] REG_FLASHCS      = 8'h03;
   localparam logic [7:0] REG_SCANCODE     = 8'h04;
   localparam logic [7:0] REG_KEYBSTAT     = 8'h05;
   localparam logic [7:0] REG_JOYCONF      = 8'h06;
   localparam logic [7:0] REG_KEYMAP       = 8'h07;
   localparam logic [7:0] REG_NMIEVENT     = 8'h08;
   localparam logic [7:0] REG_MOUSEDATA    = 8'h09;
   localparam logic [7:0] REG_MOUSESTATUS  = 8'h0A;
   localparam logic [7:0] REG_SCANDBLCTRL  = 8'h0B;
   localparam logic [7:0] REG_RASTERLINE   = 8'h0C;
   localparam logic [7:0] REG_RASTERCTRL   = 8'h0D;
   localparam logic [7:0] REG_COREID       = 8'hFF;

   // Registers below this number are write-protected while the lock is set
   localparam logic [7:0] REG_PROT_LIMIT   = 8'h10;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACCESS   = 2'd1,
      ST_WAIT_END = 2'd2
   } state_t;

endpackage

// File: rtl/zxuno_io_sync.sv
// Input stage of the register bus initiator: registers the Z80 bus signals
// once per clk (stage S1) and decodes the four access classes from the
// registered values.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   a, iorq_n, rd_n,    raw CPU bus signals
//   wr_n, m1_n, cpu_dout
//   wsel, rsel          write/read of the register-select port (S1)
//   wdat, rdat          write/read of the register-data port (S1)
//   bus_idle            S1 sample shows IORQ released
//   cpu_dout_s1         CPU write data as seen in S1
module zxuno_io_sync
   import zxuno_regbus_initiator_pkg::*;
#(
   parameter logic [15:0] ADDRPORT = ZXUNO_ADDR_PORT,
   parameter logic [15:0] DATAPORT = ZXUNO_DATA_PORT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] a,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        m1_n,
   input  logic [7:0]  cpu_dout,
   output logic        wsel,
   output logic        rsel,
   output logic        wdat,
   output logic        rdat,
   output logic        bus_idle,
   output logic [7:0]  cpu_dout_s1
);

   logic [15:0] a_p1;
   logic [7:0]  cpu_dout_p1;
   logic        iorq_n_p1;
   logic        rd_n_p1;
   logic        wr_n_p1;
   logic        m1_n_p1;
   logic        vld_p1;
   logic        io_p1;

   // ---- S1: registered bus sample ----
   // Strobes clear to inactive on reset. vld_p1 marks that at least one real
   // sample has been taken since reset, so the reset value of iorq_n_p1 is
   // never mistaken for a released bus (which would let the FSM leave
   // WAIT_END in the middle of a CPU cycle that straddled the reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iorq_n_p1 <= 1'b1;
         rd_n_p1   <= 1'b1;
         wr_n_p1   <= 1'b1;
         m1_n_p1   <= 1'b1;
         vld_p1    <= 1'b0;
      end else begin
         iorq_n_p1 <= iorq_n;
         rd_n_p1   <= rd_n;
         wr_n_p1   <= wr_n;
         m1_n_p1   <= m1_n;
         vld_p1    <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      a_p1        <= a;
      cpu_dout_p1 <= cpu_dout;
   end

   // ---- S1 decode ----
   // m1_n low during IORQ is an interrupt acknowledge, never a port access
   assign io_p1       = vld_p1 & ~iorq_n_p1 & m1_n_p1;
   assign wsel        = io_p1 & (a_p1 == ADDRPORT) & ~wr_n_p1;
   assign rsel        = io_p1 & (a_p1 == ADDRPORT) & ~rd_n_p1;
   assign wdat        = io_p1 & (a_p1 == DATAPORT) & ~wr_n_p1;
   assign rdat        = io_p1 & (a_p1 == DATAPORT) & ~rd_n_p1;
   assign bus_idle    = vld_p1 & iorq_n_p1;
   assign cpu_dout_s1 = cpu_dout_p1;

endmodule

// File: rtl/zxuno_regbus_initiator.sv
// Initiator side of the ZXUNO internal register bus. Decodes Z80 I/O cycles
// on the register-select and register-data ports, holds the selected
// register number, issues one read or write action per CPU I/O cycle to the
// register slaves, and returns slave data (or the select-port readback) to
// the CPU.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   a, iorq_n, rd_n,      CPU bus inputs
//   wr_n, m1_n, cpu_dout
//   slv_dout, slv_oe_n    combined slave read data / output enable
//   cfg_lock              write protection for low register numbers
//   zxuno_addr            selected register number
//   zxuno_regrd           read in progress (level for the whole IORQ window)
//   zxuno_regwr           one-clk write strobe
//   dout, oe_n            data and drive enable back to the CPU
module zxuno_regbus_initiator
   import zxuno_regbus_initiator_pkg::*;
#(
   parameter logic [15:0] ADDRPORT   = ZXUNO_ADDR_PORT,
   parameter logic [15:0] DATAPORT   = ZXUNO_DATA_PORT,
   parameter logic [7:0]  PROT_LIMIT = REG_PROT_LIMIT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] a,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        m1_n,
   input  logic [7:0]  cpu_dout,
   input  logic [7:0]  slv_dout,
   input  logic        slv_oe_n,
   input  logic        cfg_lock,
   output logic [7:0]  zxuno_addr,
   output logic        zxuno_regrd,
   output logic        zxuno_regwr,
   output logic [7:0]  dout,
   output logic        oe_n
);

   logic       wsel;
   logic       rsel;
   logic       wdat;
   logic       rdat;
   logic       bus_idle;
   logic [7:0] cpu_dout_s1;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] addr_nxt;
   logic       regrd_nxt;
   logic       regwr_nxt;
   logic       oe_n_nxt;
   logic       rd_sel;
   logic       rd_sel_nxt;
   logic [7:0] dout_nxt;

   zxuno_io_sync #(
      .ADDRPORT (ADDRPORT),
      .DATAPORT (DATAPORT)
   ) u_io_sync (
      .clk         (clk),
      .rst_n       (rst_n),
      .a           (a),
      .iorq_n      (iorq_n),
      .rd_n        (rd_n),
      .wr_n        (wr_n),
      .m1_n        (m1_n),
      .cpu_dout    (cpu_dout),
      .wsel        (wsel),
      .rsel        (rsel),
      .wdat        (wdat),
      .rdat        (rdat),
      .bus_idle    (bus_idle),
      .cpu_dout_s1 (cpu_dout_s1)
   );

   // ---- S2: FSM and bus outputs ----
   // Reset lands in WAIT_END so a CPU cycle already in progress when reset
   // is released has to end before any new access can be recognised.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_WAIT_END;
         zxuno_addr  <= 8'h00;
         zxuno_regrd <= 1'b0;
         zxuno_regwr <= 1'b0;
         oe_n        <= 1'b1;
         rd_sel      <= 1'b0;
         dout        <= 8'h00;
      end else begin
         state       <= state_nxt;
         zxuno_addr  <= addr_nxt;
         zxuno_regrd <= regrd_nxt;
         zxuno_regwr <= regwr_nxt;
         oe_n        <= oe_n_nxt;
         rd_sel      <= rd_sel_nxt;
         dout        <= dout_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      addr_nxt   = zxuno_addr;
      regrd_nxt  = zxuno_regrd;
      regwr_nxt  = 1'b0;
      oe_n_nxt   = oe_n;
      rd_sel_nxt = rd_sel;
      case (state)
         ST_IDLE: begin
            if (wsel | rsel | wdat | rdat) begin
               state_nxt = ST_ACCESS;
               if (wsel) begin
                  addr_nxt = cpu_dout_s1;
               end
               // A locked write to a protected register is dropped silently
               if (wdat && !(cfg_lock && (zxuno_addr < PROT_LIMIT))) begin
                  regwr_nxt = 1'b1;
               end
               if (rsel | rdat) begin
                  regrd_nxt  = rdat;
                  oe_n_nxt   = 1'b0;
                  rd_sel_nxt = rsel;
               end
            end
         end
         ST_ACCESS: begin
            state_nxt = ST_WAIT_END;
         end
         ST_WAIT_END: begin
            // Only the end of IORQ re-arms the FSM, so RD/WR glitches
            // inside one window cannot produce a second action
            if (bus_idle) begin
               state_nxt = ST_IDLE;
               regrd_nxt = 1'b0;
               oe_n_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_WAIT_END;
         end
      endcase
   end

   // Read data is refreshed every cycle of the read window; a register that
   // no slave claims reads back as FFh, like a floating Z80 data bus.
   always_comb begin
      dout_nxt = dout;
      if (!oe_n) begin
         if (rd_sel) begin
            dout_nxt = zxuno_addr;
         end else if (!slv_oe_n) begin
            dout_nxt = slv_dout;
         end else begin
            dout_nxt = 8'hFF;
         end
      end
   end

endmodule

// File: tb/tb_zxuno_regbus_initiator.sv
module tb_zxuno_regbus_initiator;

   localparam logic [15:0] PSEL = 16'hFC3B;
   localparam logic [15:0] PDAT = 16'hFD3B;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] a;
   logic        iorq_n;
   logic        rd_n;
   logic        wr_n;
   logic        m1_n;
   logic [7:0]  cpu_dout;
   logic [7:0]  slv_dout;
   logic        slv_oe_n;
   logic        cfg_lock;
   logic [7:0]  zxuno_addr;
   logic        zxuno_regrd;
   logic        zxuno_regwr;
   logic [7:0]  dout;
   logic        oe_n;

   int total = 0;
   int bad   = 0;

   int         p;
   int         rc;
   int         oc;
   logic [7:0] pa;
   logic [7:0] dw;
   logic       oa;
   logic       ra;

   always #5 clk = ~clk;

   zxuno_regbus_initiator dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a           (a),
      .iorq_n      (iorq_n),
      .rd_n        (rd_n),
      .wr_n        (wr_n),
      .m1_n        (m1_n),
      .cpu_dout    (cpu_dout),
      .slv_dout    (slv_dout),
      .slv_oe_n    (slv_oe_n),
      .cfg_lock    (cfg_lock),
      .zxuno_addr  (zxuno_addr),
      .zxuno_regrd (zxuno_regrd),
      .zxuno_regwr (zxuno_regwr),
      .dout        (dout),
      .oe_n        (oe_n)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One CPU I/O cycle: IORQ low for 6 clk, then 3 idle clk. Counts write
   // strobes, regrd-high and oe_n-low cycles over the whole span.
   task automatic io_cycle(input logic [15:0] port, input logic is_wr,
                           input logic [7:0] data, input logic m1,
                           output int pulses, output logic [7:0] pulse_addr,
                           output int rdcnt, output int oecnt,
                           output logic [7:0] dout_win,
                           output logic oe_after, output logic rd_after);
      pulses = 0; pulse_addr = 8'h00; rdcnt = 0; oecnt = 0;
      @(negedge clk);
      a = port; cpu_dout = data; m1_n = m1; iorq_n = 1'b0;
      if (is_wr) wr_n = 1'b0; else rd_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (zxuno_regwr) begin pulses++; pulse_addr = zxuno_addr; end
         if (zxuno_regrd) rdcnt++;
         if (!oe_n) oecnt++;
      end
      dout_win = dout;
      iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (zxuno_regwr) pulses++;
      end
      oe_after = oe_n;
      rd_after = zxuno_regrd;
   endtask

   initial begin
      rst_n = 1'b0; a = 16'h0000; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      m1_n = 1'b1; cpu_dout = 8'h00; slv_dout = 8'h00; slv_oe_n = 1'b1;
      cfg_lock = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_addr", zxuno_addr, 8'h00);
      chk("rst_regrd", zxuno_regrd, 1'b0);
      chk("rst_regwr", zxuno_regwr, 1'b0);
      chk("rst_dout", dout, 8'h00);
      chk("rst_oe_n", oe_n, 1'b1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Select register 0Bh and read the select port back
      io_cycle(PSEL, 1'b1, 8'h0B, 1'b1, p, pa, rc, oc, dw, oa, ra);
      chk("sel_no_regwr", p, 0);
      chk("sel_addr", zxuno_addr, 8'h0B);
      io_cycle(PSEL, 1'b0, 8'h00, 1'b1, p, pa, rc, oc, dw, oa, ra);
      chk("selrd_dout", dw, 8'h0B);
      chk("selrd_oe_cnt", oc, 5);
      chk("selrd_regrd_cnt", rc, 0);
      chk("selrd_oe_after", oa, 1'b1);

      // Data write, then a data read that must not strobe
      io_cycle(PDAT, 1'b1, 8'h85, 1'b1, p, pa, rc, oc, dw, oa, ra);
      chk("wr_pulses", p, 1);
      chk("wr_pulse_addr", pa, 8'h0B);
      chk("wr_no_oe", oc, 0);
      io_cycle(PDAT, 1'b0, 8'h00, 1'b1, p, pa, rc, oc, dw, oa, ra);
      chk("rd_after_wr_no_regwr", p, 0);

      // Write protection
      cfg_lock = 1'b1;
      io_cycle(PSEL, 1'b1, 8'h05, 1'b1, p, pa, rc, oc, dw, oa, ra);
      io_cycle(PDAT, 1'b1, 8'hFF, 1'b1, p, pa, rc, oc, dw, oa, ra);
      chk("lock_low_pulses", p, 0);
      io_cycle(PSEL, 1'b1, 8'h20, 1'b1, p, pa, rc, oc, dw, oa, ra);
      io_cycle(PDAT, 1'b1, 8'hFF, 1'b1, p, pa, rc, oc, dw, oa, ra);
      chk("lock_high_pulses", p, 1);
      chk("lock_high_addr", pa, 8'h20);
      cfg_lock = 1'b0;

      // Data reads with and without a responding slave
      io_cycle(PSEL, 1'b1, 8'h0B, 1'b1, p, pa, rc, oc, dw, oa, ra);
      slv_oe_n = 1'b0; slv_dout = 8'h81;
      io_cycle(PDAT, 1'b0, 8'h00, 1'b1, p, pa, rc, oc, dw, oa, ra);
      chk("rd_slave_dout", dw, 8'h81);
      chk("rd_regrd_cnt", rc, 5);
      chk("rd_oe_cnt", oc, 5);
      chk("rd_regrd_after", ra, 1'b0);
      chk("rd_oe_after", oa, 1'b1);
      slv_oe_n = 1'b1;
      io_cycle(PDAT, 1'b0, 8'h00, 1'b1, p, pa, rc, oc, dw, oa, ra);
      chk("rd_unimpl_dout", dw, 8'hFF);
      slv_dout = 8'h00;

      // Reset in the middle of a write, released with IORQ still low
      @(negedge clk);
      a = PDAT; cpu_dout = 8'h55; iorq_n = 1'b0; wr_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_addr", zxuno_addr, 8'h00);
      chk("midrst_regwr", zxuno_regwr, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      p = 0;
      repeat (5) begin
         @(negedge clk);
         if (zxuno_regwr) p++;
      end
      iorq_n = 1'b1; wr_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (zxuno_regwr) p++;
      end
      chk("midrst_no_regwr", p, 0);
      chk("midrst_addr_after", zxuno_addr, 8'h00);
      io_cycle(PSEL, 1'b1, 8'h0B, 1'b1, p, pa, rc, oc, dw, oa, ra);
      io_cycle(PDAT, 1'b1, 8'h12, 1'b1, p, pa, rc, oc, dw, oa, ra);
      chk("postrst_pulses", p, 1);
      chk("postrst_addr", pa, 8'h0B);

      // Non-matching port and interrupt acknowledge
      io_cycle(16'hFD3C, 1'b1, 8'h33, 1'b1, p, pa, rc, oc, dw, oa, ra);
      chk("nomatch_pulses", p, 0);
      chk("nomatch_oe", oc, 0);
      io_cycle(PDAT, 1'b0, 8'h00, 1'b0, p, pa, rc, oc, dw, oa, ra);
      chk("inta_pulses", p, 0);
      chk("inta_regrd", rc, 0);
      chk("inta_oe", oc, 0);
      io_cycle(PDAT, 1'b1, 8'h44, 1'b0, p, pa, rc, oc, dw, oa, ra);
      chk("inta_wr_pulses", p, 0);
      chk("addr_unchanged", zxuno_addr, 8'h0B);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
